// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous BCD snapshot.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppresses leading zeros on digits 3..1).
module bcd_display_scan #(
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame
);

    localparam int            CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST    = CW'(SCAN_DIV - 1);
    localparam logic [6:0]    SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]    AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;

    logic [CW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic          frame_q, frame_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic          tick;
    logic          wrap;
    logic [3:0]    digit;
    logic [6:0]    seg_act;
    logic [3:0]    an_act;

    always_comb begin
        tick    = (presc_q == LAST);
        wrap    = tick && (idx_q == 2'd3);
        presc_d = tick ? '0 : presc_q + CW'(1);
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
        // Inputs are only sampled at the frame boundary so a frame never mixes old and new digits.
        snap_d  = wrap ? {in3, in2, in1, in0} : snap_q;
        frame_d = wrap;

        case (idx_q)
            2'd0:    digit = snap_q[3:0];
            2'd1:    digit = snap_q[7:4];
            2'd2:    digit = snap_q[11:8];
            default: digit = snap_q[15:12];
        endcase

        case (digit)
            4'd0:    seg_act = 7'h3F;
            4'd1:    seg_act = 7'h06;
            4'd2:    seg_act = 7'h5B;
            4'd3:    seg_act = 7'h4F;
            4'd4:    seg_act = 7'h66;
            4'd5:    seg_act = 7'h6D;
            4'd6:    seg_act = 7'h7D;
            4'd7:    seg_act = 7'h07;
            4'd8:    seg_act = 7'h7F;
            4'd9:    seg_act = 7'h6F;
            default: seg_act = 7'h40;
        endcase

        an_act = 4'b0001 << idx_q;
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every more-significant digit are zero.
        case (idx_q)
            2'd3:    if (snap_q[15:12] == 4'd0) an_act = 4'b0000;
            2'd2:    if (snap_q[15:8] == 8'd0) an_act = 4'b0000;
            2'd1:    if (snap_q[15:4] == 12'd0) an_act = 4'b0000;
            default: an_act = an_act;
        endcase
`endif
        if (blank) an_act = 4'b0000;

        seg_d = ACTIVE_LOW ? ~seg_act : seg_act;
        an_d  = ACTIVE_LOW ? ~an_act : an_act;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            snap_q  <= 16'd0;
            frame_q <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            frame_q <= frame_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan (SCAN_DIV=4, active-high outputs) with per-cycle scoreboard.
module tb_bcd_display_scan;

    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] in0, in1, in2, in3;
    logic       blank;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame;

    int          tests = 0;
    int          fails = 0;
    int          k;
    logic [15:0] cur_snap;
    logic [11:0] exp_q[$];

    bcd_display_scan #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b0)) dut (
        .clock(clock), .reset(reset),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .blank(blank), .seg(seg), .an(an), .frame(frame)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: predict {frame, an, seg} after the coming edge, then compare.
    task automatic run_cycle();
        logic [1:0]  idx;
        logic [15:0] sh;
        logic [3:0]  a;
        logic        f;
        idx = 2'((k / SD) % 4);
        sh  = cur_snap >> (4 * idx);
        a   = 4'b0001 << idx;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 2'd3 && cur_snap[15:12] == 4'd0) a = 4'b0000;
        if (idx == 2'd2 && cur_snap[15:8] == 8'd0) a = 4'b0000;
        if (idx == 2'd1 && cur_snap[15:4] == 12'd0) a = 4'b0000;
`endif
        if (blank) a = 4'b0000;
        f = ((k + 1) % FRAME) == 0;
        exp_q.push_back({f, a, dec(sh[3:0])});
        if (f) cur_snap = {in3, in2, in1, in0};
        @(posedge clock);
        #1;
        k++;
        check($sformatf("cycle_k%0d", k), {frame, an, seg}, exp_q.pop_front());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic set_in(input logic [3:0] d3, input logic [3:0] d2,
                          input logic [3:0] d1, input logic [3:0] d0);
        in3 = d3; in2 = d2; in1 = d1; in0 = d0;
    endtask

    initial begin
        reset = 1'b1;
        blank = 1'b0;
        set_in(4'd1, 4'd2, 4'd3, 4'd4);
        #1;
        check("reset_seg", {5'd0, seg}, 12'h000);
        check("reset_an", {8'd0, an}, 12'h000);
        check("reset_frame", {11'd0, frame}, 12'h000);
        #21;
        reset    = 1'b0;
        k        = 0;
        cur_snap = 16'h0000;

        // First frame shows zeros, next shows 1,2,3,4.
        run(2 * FRAME);

        // Snapshot of zeros, then 9999 applied mid-frame must wait for the boundary.
        set_in(4'd0, 4'd0, 4'd0, 4'd0);
        run(FRAME);
        run(6);
        set_in(4'd9, 4'd9, 4'd9, 4'd9);
        run(FRAME - 6);
        run(FRAME);

        // Non-BCD code shows a dash; change lands in the boundary cycle itself.
        run(FRAME - 1);
        set_in(4'd0, 4'd0, 4'd0, 4'd10);
        run(1);
        run(FRAME);

        // Blank from cycle 5 spanning a frame boundary.
        run(5);
        blank = 1'b1;
        run(20);
        blank = 1'b0;
        run(FRAME - 9);

        // Leading zeros.
        set_in(4'd0, 4'd0, 4'd0, 4'd7);
        run(2 * FRAME);

        // Reset in the middle of slot 2.
        run(9);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_seg", {5'd0, seg}, 12'h000);
        check("midreset_an", {8'd0, an}, 12'h000);
        check("midreset_frame", {11'd0, frame}, 12'h000);
        #1;
        reset    = 1'b0;
        k        = 0;
        cur_snap = 16'h0000;
        run(FRAME + 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per digit slot; legal range is 2 or more.
REQ-002 Parameter ACTIVE_LOW, default 1: when 1, seg and an are driven active-low; when 0, they are driven active-high.
REQ-003 Port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Ports in0, in1, in2, in3, input, 4 bits each: BCD digits from the stopwatch; in0 is least significant.
REQ-006 Port blank, input, 1 bit: when 1, forces all digit enables inactive.
REQ-007 Port seg, output, 7 bits: segment drive, seg[6:0] = g..a.
REQ-008 Port an, output, 4 bits: one-hot digit enable; an[i] selects digit i.
REQ-009 Port frame, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-010 The prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; a tick SHALL occur in the cycle the count equals SCAN_DIV-1.
REQ-011 A 2-bit digit index SHALL advance on each tick and wrap from 3 to 0.
REQ-012 On the tick where the index wraps 3->0, a snapshot register SHALL capture in0..in3 at that same edge, and frame SHALL be 1 for exactly that cycle.
REQ-013 Displayed digits SHALL come only from the snapshot; input changes mid-frame SHALL NOT be visible until the next frame boundary (no tearing).
REQ-014 seg and an SHALL be registered; they SHALL reflect the index one cycle after the index changes.
REQ-015 Decode (active-high, hex) SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
REQ-016 Codes 10..15 SHALL display a dash (40, g only).
REQ-017 When blank=1, an SHALL be all inactive from the next cycle; the prescaler, index and snapshot SHALL continue unaffected, and frame period SHALL be unchanged.
REQ-018 When an input changes in the same cycle as a snapshot, the value present at that edge SHALL be captured.
REQ-019 The frame period SHALL be exactly 4*SCAN_DIV cycles.

Reset
REQ-020 While reset=1, the following SHALL hold immediately (asynchronously):
- prescaler = 0, index = 0, snapshot = 0;
- frame = 0;
- seg and an all inactive, per ACTIVE_LOW polarity.
REQ-021 In the first cycle after reset release, an SHALL select digit 0 showing snapshot 0 (pattern 3F); the first frame pulse SHALL occur 4*SCAN_DIV cycles later.
REQ-022 Reset asserted mid-frame SHALL abort the frame; no frame pulse and no snapshot update SHALL occur.

Configuration
REQ-023 Macro LEADING_ZERO_BLANK_EN, when defined: a snapshot digit i (i = 3, 2, 1) whose value and all more-significant snapshot digits are 0 SHALL have an[i] inactive during its slot; digit 0 SHALL never be blanked.
REQ-024 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be shown, including zeros.

Verification (SCAN_DIV=4, ACTIVE_LOW=0)
REQ-025 Reset release, in3..in0 = 1,2,3,4 -> after the first frame pulse, an cycles 0001/0010/0100/1000 for 4 cycles each, with seg = 66/4F/5B/06 respectively.
REQ-026 Snapshot 0000, inputs changed to 9999 at cycle 6 of a frame -> seg stays 3F on all slots until the next frame pulse, then shows 6F.
REQ-027 in0 = 1010 -> slot 0 shows seg = 40 after the next frame boundary.
REQ-028 blank=1 at cycle 5 -> an = 0000 from cycle 6; frame pulses continue every 16 cycles; blank=0 -> the current slot reappears the next cycle.
REQ-029 in3..in0 = 0,0,0,7 -> with LEADING_ZERO_BLANK_EN, only an0 is active (seg 07); without it, slots 1..3 show 3F.
REQ-030 reset pulsed mid-slot 2 -> seg and an inactive and frame = 0 the same cycle; after release the index restarts at 0 and the snapshot is 0.
